// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Header layout: [31:16] magic, [15:0] payload word count.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  localparam logic [15:0] LOADER_MAGIC = 16'hC0DE;
  localparam int          HDR_MAGIC_W  = 16;
  localparam int          HDR_COUNT_W  = 16;

endpackage

// File: rtl/program_loader.sv
// Boot loader: header (magic + count), payload written to IMEM from BASE_ADDR, then cpu_start.
// Optional trailing 32-bit wrap-around payload checksum when CHECKSUM_EN is defined.
module program_loader
  import loader_pkg::*;
#(
  parameter int                ADDR_W    = 14,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [15:0]       MAGIC     = LOADER_MAGIC
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       rx_data,
  input  logic              rx_valid,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_start,
  output logic              busy,
  output logic              err,
  output logic [15:0]       words_left
);

  // Largest payload that fits between BASE_ADDR and the top of IMEM.
  localparam logic [32:0] LIMIT = (33'd1 << ADDR_W) - 33'(BASE_ADDR);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [31:0]       r_wdata;
  logic              r_cpu_start;
  logic              r_busy;
  logic              r_err;
  logic [15:0]       r_words_left;
`ifdef CHECKSUM_EN
  logic [31:0]       r_acc;
`endif

  logic [HDR_MAGIC_W-1:0] w_magic;
  logic [HDR_COUNT_W-1:0] w_count;
  logic                   w_too_big;

  assign w_magic   = rx_data[31:16];
  assign w_count   = rx_data[15:0];
  assign w_too_big = {17'b0, w_count} > LIMIT;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_addr       <= BASE_ADDR;
      r_we         <= 1'b0;
      r_imem_addr  <= '0;
      r_wdata      <= '0;
      r_cpu_start  <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      r_words_left <= '0;
`ifdef CHECKSUM_EN
      r_acc        <= '0;
`endif
    end else begin
      r_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Words without the magic are treated as line noise and dropped.
          if (rx_valid && w_magic == MAGIC) begin
            if (w_count == '0) begin
`ifdef CHECKSUM_EN
              r_state <= ST_CHECK;
              r_busy  <= 1'b1;
`else
              r_state     <= ST_DONE;
              r_cpu_start <= 1'b1;
`endif
            end else if (w_too_big) begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end else begin
              r_words_left <= w_count;
              r_busy       <= 1'b1;
              r_state      <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (rx_valid) begin
            r_we         <= 1'b1;
            r_wdata      <= rx_data;
            r_imem_addr  <= r_addr;
            r_addr       <= r_addr + ADDR_W'(1);
            r_words_left <= r_words_left - 16'd1;
`ifdef CHECKSUM_EN
            r_acc <= r_acc + rx_data;
            if (r_words_left == 16'd1) r_state <= ST_CHECK;
`else
            if (r_words_left == 16'd1) begin
              r_state     <= ST_DONE;
              r_busy      <= 1'b0;
              r_cpu_start <= 1'b1;
            end
`endif
          end
        end
`ifdef CHECKSUM_EN
        ST_CHECK: begin
          if (rx_valid) begin
            r_busy <= 1'b0;
            if (rx_data == r_acc) begin
              r_state     <= ST_DONE;
              r_cpu_start <= 1'b1;
            end else begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end
          end
        end
`endif
        ST_DONE: r_state <= ST_DONE;
        ST_ERR:  r_state <= ST_ERR;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_wdata;
  assign cpu_start  = r_cpu_start;
  assign busy       = r_busy;
  assign err        = r_err;
  assign words_left = r_words_left;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader; checksum scenarios build only with CHECKSUM_EN defined.
module tb_program_loader;

  localparam int ADDR_W = 14;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [31:0]       rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_start;
  logic              busy;
  logic              err;
  logic [15:0]       words_left;

  int n_checks = 0;
  int n_errors = 0;

  logic [ADDR_W-1:0] log_addr[$];
  logic [31:0]       log_data[$];

  program_loader #(.ADDR_W(ADDR_W), .BASE_ADDR('0), .MAGIC(16'hC0DE)) dut (
    .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_start(cpu_start), .busy(busy), .err(err), .words_left(words_left)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (imem_we) begin
      log_addr.push_back(imem_addr);
      log_data.push_back(imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] w);
    @(negedge CLK);
    rx_data  = w;
    rx_valid = 1'b1;
    @(negedge CLK);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    idle(1);
  endtask

  // Trailing checksum word only exists in the checksum build.
  task automatic send_csum(input logic [31:0] s);
`ifdef CHECKSUM_EN
    send(s);
`else
    if (s == 32'hFFFF_FFFF) $display("unused csum %h", s);
`endif
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".we"},    32'(imem_we), 0);
    check({tag, ".start"}, 32'(cpu_start), 0);
    check({tag, ".busy"},  32'(busy), 0);
    check({tag, ".err"},   32'(err), 0);
    check({tag, ".left"},  32'(words_left), 0);
  endtask

  initial begin
    logic [31:0] a, b, c;
    int base;

    // Reset state
    do_reset();
    check_idle_outputs("rst");
    check("rst.addr", 32'(imem_addr), 0);

    // 1: three-word load, one-cycle write latency
    a = 32'hDEAD_BEEF; b = 32'h0000_0001; c = 32'h1234_5678;
    base = log_addr.size();
    send(32'hC0DE_0003);
    check("t1.busy", 32'(busy), 1);
    check("t1.left", 32'(words_left), 3);
    @(negedge CLK); rx_data = a; rx_valid = 1'b1;
    @(negedge CLK); rx_valid = 1'b0;
    check("t1.we_lat",  32'(imem_we), 1);
    check("t1.addr0",   32'(imem_addr), 0);
    check("t1.data0",   imem_wdata, a);
    check("t1.left2",   32'(words_left), 2);
    send(b);
    send(c);
    send_csum(a + b + c);
    idle(2);
    check("t1.nwr", 32'(log_addr.size() - base), 3);
    for (int i = 0; i < 3 && base + i < log_addr.size(); i++) begin
      check($sformatf("t1.a%0d", i), 32'(log_addr[base+i]), 32'(i));
    end
    if (log_data.size() >= base + 3) begin
      check("t1.d1", log_data[base+1], b);
      check("t1.d2", log_data[base+2], c);
    end
    check("t1.start", 32'(cpu_start), 1);
    check("t1.busy0", 32'(busy), 0);
    check("t1.err",   32'(err), 0);
    send(32'hC0DE_0001);
    send(32'h5555_5555);
    idle(2);
    check("t1.done_ign", 32'(log_addr.size() - base), 3);

    // 2: noise ignored, then two-word load
    do_reset();
    base = log_addr.size();
    send(32'h1234_0005);
    check("t2.noise_busy", 32'(busy), 0);
    check("t2.noise_left", 32'(words_left), 0);
    send(32'hC0DE_0002);
    send(32'h1111_1111);
    send(32'h2222_2222);
    send_csum(32'h3333_3333);
    idle(2);
    check("t2.nwr", 32'(log_addr.size() - base), 2);
    if (log_data.size() >= base + 2) begin
      check("t2.a1", 32'(log_addr[base+1]), 1);
      check("t2.d1", log_data[base+1], 32'h2222_2222);
    end
    check("t2.start", 32'(cpu_start), 1);

    // 3: empty payload
    do_reset();
    base = log_addr.size();
    send(32'hC0DE_0000);
    send_csum(32'h0);
    idle(2);
    check("t3.nwr",   32'(log_addr.size() - base), 0);
    check("t3.start", 32'(cpu_start), 1);
    check("t3.busy",  32'(busy), 0);

    // 4: oversize counts; 16384 is the largest that fits
    do_reset();
    base = log_addr.size();
    send(32'hC0DE_FFFF);
    check("t4.err",   32'(err), 1);
    check("t4.busy",  32'(busy), 0);
    send(32'hC0DE_0001);
    send(32'hAAAA_AAAA);
    idle(2);
    check("t4.nwr",   32'(log_addr.size() - base), 0);
    check("t4.start", 32'(cpu_start), 0);
    do_reset();
    send(32'hC0DE_4001);
    check("t4.over1", 32'(err), 1);
    do_reset();
    send(32'hC0DE_4000);
    check("t4.max_err",  32'(err), 0);
    check("t4.max_left", 32'(words_left), 16'h4000);

    // 5: reset mid-load, then restart from base
    do_reset();
    send(32'hC0DE_0003);
    send(32'h0000_0077);
    do_reset();
    check_idle_outputs("t5.rst");
    base = log_addr.size();
    send(32'hC0DE_0002);
    send(32'h0000_00AA);
    send(32'h0000_00BB);
    send_csum(32'h0000_0165);
    idle(2);
    check("t5.nwr", 32'(log_addr.size() - base), 2);
    if (log_addr.size() >= base + 2) begin
      check("t5.a0", 32'(log_addr[base]), 0);
      check("t5.d0", log_data[base], 32'h0000_00AA);
      check("t5.a1", 32'(log_addr[base+1]), 1);
    end
    check("t5.start", 32'(cpu_start), 1);

`ifdef CHECKSUM_EN
    // 6: checksum good and bad
    do_reset();
    send(32'hC0DE_0003);
    send(32'd1); send(32'd2); send(32'd3);
    idle(1);
    check("t6.check_busy", 32'(busy), 1);
    check("t6.pre_start",  32'(cpu_start), 0);
    send(32'd6);
    check("t6.good_start", 32'(cpu_start), 1);
    check("t6.good_err",   32'(err), 0);
    do_reset();
    send(32'hC0DE_0003);
    send(32'd1); send(32'd2); send(32'd3);
    send(32'd7);
    check("t6.bad_err",   32'(err), 1);
    check("t6.bad_start", 32'(cpu_start), 0);
    do_reset();
    send(32'hC0DE_0000);
    send(32'd1);
    check("t6.empty_bad", 32'(err), 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
